// File: rtl/fb_port_arbiter_pkg.sv
// Shared constants and FSM state type for the framebuffer port-A arbiter.
package fb_pkg;
  localparam int FB_AW    = 12;
  localparam int FB_DW    = 24;
  localparam int FB_DEPTH = 96 * 1 * 48 / 2;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester, clear-control and memory port-A signals of the framebuffer arbiter.
interface fb_port_arbiter_if
  import fb_pkg::*;
#(
  parameter int AW = FB_AW,
  parameter int DW = FB_DW
);
  logic          i_r0_valid;
  logic          i_r0_we;
  logic [AW-1:0] i_r0_addr;
  logic [DW-1:0] i_r0_wdata;
  logic          o_r0_ready;
  logic          o_r0_rvalid;
  logic [DW-1:0] o_r0_rdata;
  logic          i_r1_valid;
  logic          i_r1_we;
  logic [AW-1:0] i_r1_addr;
  logic [DW-1:0] i_r1_wdata;
  logic          o_r1_ready;
  logic          o_r1_rvalid;
  logic [DW-1:0] o_r1_rdata;
  logic          i_clear_start;
  logic [DW-1:0] i_clear_value;
  logic          o_clear_busy;
  logic          o_clear_done;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic          o_mem_re;
  logic [DW-1:0] i_mem_rdata;

  modport slave (
    input  i_r0_valid, i_r0_we, i_r0_addr, i_r0_wdata,
    output o_r0_ready, o_r0_rvalid, o_r0_rdata,
    input  i_r1_valid, i_r1_we, i_r1_addr, i_r1_wdata,
    output o_r1_ready, o_r1_rvalid, o_r1_rdata,
    input  i_clear_start, i_clear_value,
    output o_clear_busy, o_clear_done,
    output o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
    input  i_mem_rdata
  );

  modport master (
    output i_r0_valid, i_r0_we, i_r0_addr, i_r0_wdata,
    input  o_r0_ready, o_r0_rvalid, o_r0_rdata,
    output i_r1_valid, i_r1_we, i_r1_addr, i_r1_wdata,
    input  o_r1_ready, o_r1_rvalid, o_r1_rdata,
    output i_clear_start, i_clear_value,
    input  o_clear_busy, o_clear_done,
    input  o_mem_addr, o_mem_wdata, o_mem_we, o_mem_re,
    output i_mem_rdata
  );
endinterface

// File: rtl/fb_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer names the requester favoured on a tie.
module fb_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);
  logic ptr_q, ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    ptr_d = ptr_q;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = ptr_q ? 2'b10 : 2'b01;
        default: o_gnt = 2'b00;
      endcase
    end
    // After a grant the other requester wins the next tie.
    if (o_gnt[0])      ptr_d = 1'b1;
    else if (o_gnt[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// Port-A owner of the RGB framebuffer: round-robin between two requesters plus a
// full-memory clear sequencer, with a two-stage read-return pipeline.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 48,
  parameter int CHAINED = 1,
  parameter int AW      = 12,
  parameter int DW      = 24
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fb_port_arbiter_if.slave bus
);
  localparam int              DEPTH     = WIDTH * CHAINED * HEIGHT / 2;
  localparam logic [AW:0]     DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d, mem_addr_q, mem_addr_d;
  logic [DW-1:0] clr_val_q, clr_val_d, mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d, mem_re_q, mem_re_d, done_q, done_d;
  logic          vld_p1_q, vld_p1_d, id_p1_q, id_p1_d, ok_p1_q, ok_p1_d;
  logic          vld_p2_q, vld_p2_d, id_p2_q, id_p2_d, ok_p2_q, ok_p2_d;
  logic [1:0]    req, gnt;
  logic          arb_en, acc, sel_we, sel_ok;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req       = {bus.i_r1_valid, bus.i_r0_valid};
  assign arb_en    = (state_q == ST_IDLE) && !bus.i_clear_start;
  assign acc       = |gnt;
  assign sel_we    = gnt[1] ? bus.i_r1_we    : bus.i_r0_we;
  assign sel_addr  = gnt[1] ? bus.i_r1_addr  : bus.i_r0_addr;
  assign sel_wdata = gnt[1] ? bus.i_r1_wdata : bus.i_r0_wdata;
  assign sel_ok    = ({1'b0, sel_addr} < DEPTH_W);

  fb_rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (arb_en),
    .i_req   (req),
    .o_gnt   (gnt)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_val_d   = clr_val_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    done_d      = 1'b0;
    vld_p1_d    = acc && !sel_we;
    id_p1_d     = gnt[1];
    ok_p1_d     = sel_ok;
    vld_p2_d    = vld_p1_q;
    id_p2_d     = id_p1_q;
    ok_p2_d     = ok_p1_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_clear_start) begin
          state_d     = ST_CLEAR;
          cnt_d       = '0;
          clr_val_d   = bus.i_clear_value;
          mem_addr_d  = '0;
          mem_wdata_d = bus.i_clear_value;
          mem_we_d    = 1'b1;
        end else if (acc && sel_ok) begin
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_we ? sel_wdata : mem_wdata_q;
          mem_we_d    = sel_we;
          mem_re_d    = !sel_we;
        end
      end
      ST_CLEAR: begin
        // cnt_q is the address being written this cycle; queue the next one.
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          mem_addr_d  = cnt_q + 1'b1;
          mem_wdata_d = clr_val_q;
          mem_we_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage boundary: memory strobes and read-return pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      done_q      <= 1'b0;
      vld_p1_q    <= 1'b0;
      id_p1_q     <= 1'b0;
      ok_p1_q     <= 1'b0;
      vld_p2_q    <= 1'b0;
      id_p2_q     <= 1'b0;
      ok_p2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      done_q      <= done_d;
      vld_p1_q    <= vld_p1_d;
      id_p1_q     <= id_p1_d;
      ok_p1_q     <= ok_p1_d;
      vld_p2_q    <= vld_p2_d;
      id_p2_q     <= id_p2_d;
      ok_p2_q     <= ok_p2_d;
    end
  end

  always_ff @(posedge i_clk) begin
    clr_val_q <= clr_val_d;
  end

  assign bus.o_r0_ready   = gnt[0];
  assign bus.o_r1_ready   = gnt[1];
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_wdata  = mem_wdata_q;
  assign bus.o_mem_we     = mem_we_q;
  assign bus.o_mem_re     = mem_re_q;
  assign bus.o_clear_busy = (state_q == ST_CLEAR);
  assign bus.o_clear_done = done_q;
  assign bus.o_r0_rvalid  = vld_p2_q & ~id_p2_q;
  assign bus.o_r1_rvalid  = vld_p2_q & id_p2_q;
  // Out-of-range reads return zero instead of whatever the memory holds.
  assign bus.o_r0_rdata   = (vld_p2_q & ~id_p2_q & ok_p2_q) ? bus.i_mem_rdata : '0;
  assign bus.o_r1_rdata   = (vld_p2_q & id_p2_q & ok_p2_q) ? bus.i_mem_rdata : '0;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port memory on port A.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fb_port_arbiter_if bus ();

  fb_port_arbiter dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.o_mem_we) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
    if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.i_r0_valid = 0; bus.i_r0_we = 0; bus.i_r0_addr = '0; bus.i_r0_wdata = '0;
    bus.i_r1_valid = 0; bus.i_r1_we = 0; bus.i_r1_addr = '0; bus.i_r1_wdata = '0;
    bus.i_clear_start = 0; bus.i_clear_value = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.o_mem_we); end
    checks++; if (bus.o_mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b want 0", bus.o_mem_re); end
    checks++; if (bus.o_mem_addr !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", bus.o_mem_addr); end
    checks++; if (bus.o_mem_wdata !== 24'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 000000", bus.o_mem_wdata); end
    checks++; if (bus.o_clear_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_clear_busy); end
    checks++; if (bus.o_clear_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.o_clear_done); end
    checks++; if (bus.o_r0_rvalid !== 1'b0 || bus.o_r1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got r0=%b r1=%b want 0 0", bus.o_r0_rvalid, bus.o_r1_rvalid); end
    checks++; if (bus.o_r0_rdata !== 24'h0 || bus.o_r1_rdata !== 24'h0) begin errors++; $display("FAIL reset_rdata: got r0=%h r1=%h want 0 0", bus.o_r0_rdata, bus.o_r1_rdata); end
    @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic test_round_robin;
    int g0, g1;
    logic exp0;
    g0 = 0; g1 = 0;
    bus.i_r0_valid = 1; bus.i_r0_we = 1; bus.i_r0_addr = 12'h100; bus.i_r0_wdata = 24'h000A00;
    bus.i_r1_valid = 1; bus.i_r1_we = 1; bus.i_r1_addr = 12'h200; bus.i_r1_wdata = 24'h000B00;
    for (int i = 0; i < 6; i++) begin
      exp0 = (i % 2 == 0);
      @(negedge clk);
      checks++; if (bus.o_r0_ready !== exp0 || bus.o_r1_ready !== !exp0) begin errors++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b want r0=%b r1=%b", i, bus.o_r0_ready, bus.o_r1_ready, exp0, !exp0); end
      if (bus.o_r0_ready === 1'b1) g0++;
      if (bus.o_r1_ready === 1'b1) g1++;
      tick();
      checks++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== (exp0 ? 12'h100 : 12'h200)) begin errors++; $display("FAIL rr_mem[%0d]: got we=%b addr=%h want we=1 addr=%h", i, bus.o_mem_we, bus.o_mem_addr, exp0 ? 12'h100 : 12'h200); end
    end
    idle_inputs();
    checks++; if (g0 != 3 || g1 != 3) begin errors++; $display("FAIL rr_counts: got r0=%0d r1=%0d want 3 3", g0, g1); end
    tick();
  endtask

  task automatic test_write_read;
    bus.i_r0_valid = 1; bus.i_r0_we = 1; bus.i_r0_addr = 12'h010; bus.i_r0_wdata = 24'h123456;
    @(negedge clk);
    checks++; if (bus.o_r0_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", bus.o_r0_ready); end
    tick();
    checks++; if (bus.o_mem_we !== 1'b1 || bus.o_mem_re !== 1'b0 || bus.o_mem_addr !== 12'h010 || bus.o_mem_wdata !== 24'h123456) begin errors++; $display("FAIL wr_strobe: got we=%b re=%b addr=%h data=%h want 1 0 010 123456", bus.o_mem_we, bus.o_mem_re, bus.o_mem_addr, bus.o_mem_wdata); end
    bus.i_r0_we = 0;
    @(negedge clk);
    checks++; if (bus.o_r0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b want 1", bus.o_r0_ready); end
    tick();
    bus.i_r0_valid = 0;
    checks++; if (bus.o_mem_re !== 1'b1 || bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 12'h010) begin errors++; $display("FAIL rd_strobe: got re=%b we=%b addr=%h want 1 0 010", bus.o_mem_re, bus.o_mem_we, bus.o_mem_addr); end
    checks++; if (bus.o_r0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_early: got rvalid=%b want 0", bus.o_r0_rvalid); end
    tick();
    checks++; if (bus.o_r0_rvalid !== 1'b1 || bus.o_r0_rdata !== 24'h123456) begin errors++; $display("FAIL rd_return: got rvalid=%b rdata=%h want 1 123456", bus.o_r0_rvalid, bus.o_r0_rdata); end
    checks++; if (bus.o_r1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_wrong_port: got r1_rvalid=%b want 0", bus.o_r1_rvalid); end
    tick();
  endtask

  task automatic test_out_of_range;
    bus.i_r1_valid = 1; bus.i_r1_we = 0; bus.i_r1_addr = 12'h900;
    @(negedge clk);
    checks++; if (bus.o_r1_ready !== 1'b1) begin errors++; $display("FAIL oor_ready: got %b want 1", bus.o_r1_ready); end
    tick();
    bus.i_r1_valid = 0;
    checks++; if (bus.o_mem_re !== 1'b0 || bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL oor_strobe: got re=%b we=%b want 0 0", bus.o_mem_re, bus.o_mem_we); end
    tick();
    checks++; if (bus.o_r1_rvalid !== 1'b1 || bus.o_r1_rdata !== 24'h0) begin errors++; $display("FAIL oor_return: got rvalid=%b rdata=%h want 1 000000", bus.o_r1_rvalid, bus.o_r1_rdata); end
    checks++; if (bus.o_r0_rvalid !== 1'b0) begin errors++; $display("FAIL oor_wrong_port: got r0_rvalid=%b want 0", bus.o_r0_rvalid); end
    tick();
  endtask

  task automatic test_read_then_clear;
    bus.i_r0_valid = 1; bus.i_r0_we = 0; bus.i_r0_addr = 12'h010;
    @(negedge clk);
    checks++; if (bus.o_r0_ready !== 1'b1) begin errors++; $display("FAIL rtc_ready: got %b want 1", bus.o_r0_ready); end
    tick();
    bus.i_r0_valid = 0;
    bus.i_clear_start = 1; bus.i_clear_value = 24'h5A5A5A;
    checks++; if (bus.o_mem_re !== 1'b1) begin errors++; $display("FAIL rtc_strobe: got re=%b want 1", bus.o_mem_re); end
    tick();
    bus.i_clear_start = 0;
    checks++; if (bus.o_r0_rvalid !== 1'b1 || bus.o_r0_rdata !== 24'h123456) begin errors++; $display("FAIL rtc_return: got rvalid=%b rdata=%h want 1 123456", bus.o_r0_rvalid, bus.o_r0_rdata); end
    checks++; if (bus.o_clear_busy !== 1'b1 || bus.o_mem_we !== 1'b1 || bus.o_mem_addr !== 12'h000) begin errors++; $display("FAIL rtc_clear_first: got busy=%b we=%b addr=%h want 1 1 000", bus.o_clear_busy, bus.o_mem_we, bus.o_mem_addr); end
  endtask

  task automatic test_reset_mid_clear;
    logic found;
    int bad;
    found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      if (bus.o_mem_we === 1'b1 && bus.o_mem_addr === 12'd1000) found = 1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL rmc_reach_1000: got not reached want write at 1000"); end
    #2 rst_n = 0;
    #1;
    checks++; if (bus.o_mem_we !== 1'b0 || bus.o_mem_addr !== 12'h000 || bus.o_mem_wdata !== 24'h0) begin errors++; $display("FAIL rmc_mem_async: got we=%b addr=%h data=%h want 0 000 000000", bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata); end
    checks++; if (bus.o_clear_busy !== 1'b0 || bus.o_clear_done !== 1'b0) begin errors++; $display("FAIL rmc_ctrl_async: got busy=%b done=%b want 0 0", bus.o_clear_busy, bus.o_clear_done); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    bad = 0;
    repeat (2400) begin
      tick();
      if (bus.o_clear_busy !== 1'b0 || bus.o_clear_done !== 1'b0 || bus.o_mem_we !== 1'b0 || bus.o_mem_re !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmc_after_release: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_clear;
    int bad, ready_bad;
    logic seen;
    logic [11:0] raddr [4];
    raddr[0] = 12'd0; raddr[1] = 12'd1151; raddr[2] = 12'd2303; raddr[3] = 12'd777;
    bus.i_clear_start = 1; bus.i_clear_value = 24'hABCABC;
    bus.i_r1_valid = 1; bus.i_r1_we = 0; bus.i_r1_addr = 12'h005;
    @(negedge clk);
    checks++; if (bus.o_r1_ready !== 1'b0) begin errors++; $display("FAIL clr_start_ready: got %b want 0", bus.o_r1_ready); end
    tick();
    bus.i_clear_start = 0;
    bad = 0; ready_bad = 0;
    for (int k = 0; k < 2304; k++) begin
      if (bus.o_mem_we !== 1'b1 || bus.o_mem_re !== 1'b0 || bus.o_mem_addr !== 12'(k) ||
          bus.o_mem_wdata !== 24'hABCABC || bus.o_clear_busy !== 1'b1 || bus.o_clear_done !== 1'b0) bad++;
      if (bus.o_r1_ready !== 1'b0) ready_bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clr_sequence: got %0d bad cycles want 0", bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL clr_ready_blocked: got %0d ready cycles want 0", ready_bad); end
    checks++; if (bus.o_clear_done !== 1'b1 || bus.o_clear_busy !== 1'b0 || bus.o_mem_we !== 1'b0) begin errors++; $display("FAIL clr_done: got done=%b busy=%b we=%b want 1 0 0", bus.o_clear_done, bus.o_clear_busy, bus.o_mem_we); end
    seen = 0;
    for (int k = 0; k < 3 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_r1_ready === 1'b1) seen = 1;
      tick();
    end
    bus.i_r1_valid = 0;
    checks++; if (!seen) begin errors++; $display("FAIL clr_r1_granted: got no ready want ready after done"); end
    checks++; if (bus.o_clear_done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got done=%b want 0", bus.o_clear_done); end
    tick(); tick();
    for (int j = 0; j < 4; j++) begin
      bus.i_r0_valid = 1; bus.i_r0_we = 0; bus.i_r0_addr = raddr[j];
      tick();
      bus.i_r0_valid = 0;
      tick();
      checks++; if (bus.o_r0_rvalid !== 1'b1 || bus.o_r0_rdata !== 24'hABCABC) begin errors++; $display("FAIL clr_readback[%0d]: got rvalid=%b rdata=%h want 1 abcabc", raddr[j], bus.o_r0_rvalid, bus.o_r0_rdata); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write_read();
    test_out_of_range();
    test_read_then_clear();
    test_reset_mid_clear();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
